// File: rtl/ex_div_if.sv
// Handshake and data bundle between the execute stage and the multi-cycle divider.
// The execute stage drives the master side and the divider sits on the slave side.
interface ex_div_if #(
    parameter int DATA_W = 32
);
    logic                  start_i;
    logic                  annul_i;
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider for the execute stage, signed or unsigned, result {remainder, quotient}.
// Optional DIV_EARLY_EXIT_EN: finish in one iteration slot when |dividend| < |divisor|.
//
// state  | meaning
// FREE   | idle, waiting for a start request
// BYZERO | divisor was zero, zero result is produced next cycle
// ON     | one restoring iteration per cycle, then sign fix-up
// END    | result valid, held until start_i drops
module ex_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input logic     clk,
    input logic     rst,
    ex_div_if.slave div
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_W-1:0]     dvd;
    logic [DATA_W-1:0]     dsr;
    logic [DATA_W-1:0]     rem;
    logic                  neg_quo;
    logic                  neg_rem;
    logic [2*DATA_W-1:0]   result;
    logic                  ready;

    logic [DATA_W-1:0]     mag1;
    logic [DATA_W-1:0]     mag2;
    logic [DATA_W:0]       rem_sh;
    logic                  fits;
    logic [DATA_W-1:0]     trial;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;

    assign mag1 = (div.signed_div_i && div.opdata1_i[DATA_W-1]) ? -div.opdata1_i : div.opdata1_i;
    assign mag2 = (div.signed_div_i && div.opdata2_i[DATA_W-1]) ? -div.opdata2_i : div.opdata2_i;

    // Shifted partial remainder is DATA_W+1 bits; when it fits, the difference is below the divisor
    // so the low DATA_W bits of the subtraction are exact.
    assign rem_sh = {rem, dvd[DATA_W-1]};
    assign fits   = rem_sh >= {1'b0, dsr};
    assign trial  = rem_sh[DATA_W-1:0] - dsr;

    assign quo_fix = neg_quo ? -dvd : dvd;
    assign rem_fix = neg_rem ? -rem : rem;

    assign div.result_o = result;
    assign div.ready_o  = ready;
    assign div.busy_o   = (state == BYZERO) || (state == ON);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FREE;
            cnt     <= '0;
            dvd     <= '0;
            dsr     <= '0;
            rem     <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else if (div.annul_i && state != FREE) begin
            state  <= FREE;
            result <= '0;
            ready  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    result <= '0;
                    ready  <= 1'b0;
                    if (div.start_i && !div.annul_i) begin
                        if (div.opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            dsr     <= mag2;
                            neg_quo <= div.signed_div_i &&
                                       (div.opdata1_i[DATA_W-1] ^ div.opdata2_i[DATA_W-1]);
                            neg_rem <= div.signed_div_i && div.opdata1_i[DATA_W-1];
                            state   <= ON;
`ifdef DIV_EARLY_EXIT_EN
                            // Small dividend: preload the finished state so ON only does the fix-up.
                            if (mag1 < mag2) begin
                                rem <= mag1;
                                dvd <= '0;
                                cnt <= CNT_W'(DATA_W);
                            end else begin
                                rem <= '0;
                                dvd <= mag1;
                                cnt <= '0;
                            end
`else
                            rem <= '0;
                            dvd <= mag1;
                            cnt <= '0;
`endif
                        end
                    end
                end
                BYZERO: begin
                    result <= '0;
                    ready  <= 1'b1;
                    state  <= END;
                end
                ON: begin
                    if (cnt == CNT_W'(DATA_W)) begin
                        result <= {rem_fix, quo_fix};
                        ready  <= 1'b1;
                        state  <= END;
                    end else begin
                        rem <= fits ? trial : rem_sh[DATA_W-1:0];
                        dvd <= {dvd[DATA_W-2:0], fits};
                        cnt <= cnt + 1'b1;
                    end
                end
                END: begin
                    if (!div.start_i) begin
                        state  <= FREE;
                        result <= '0;
                        ready  <= 1'b0;
                    end
                end
                default: begin
                    state  <= FREE;
                    result <= '0;
                    ready  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed and randomized divides against an arithmetic model.
// Build with DIV_EARLY_EXIT_EN defined to check the early-exit latency.
module tb_ex_div;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ex_div_if #(.DATA_W(32)) bus ();

    ex_div #(.DATA_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .div (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                                 input logic sgn);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int model_latency(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
        logic [31:0] ma, mb;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_EXIT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    // Starts a divide, scrambles the operand inputs while busy, returns when ready or timed out.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output int lat, output int bcnt, output logic [63:0] res);
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = sgn;
        @(posedge clk); #1;
        lat  = 0;
        bcnt = 0;
        while (!bus.ready_o && lat < 100) begin
            if (bus.busy_o) bcnt++;
            bus.opdata1_i    = $urandom;
            bus.opdata2_i    = $urandom;
            bus.signed_div_i = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result_o;
    endtask

    task automatic drop_start();
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 64'd0) begin
            failures++;
            $display("FAIL reset: ready=%b busy=%b result=%h required 0/0/0",
                     bus.ready_o, bus.busy_o, bus.result_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_div(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn);
        int lat, bcnt, elat;
        logic [63:0] res, exp;
        exp  = model_result(a, b, sgn);
        elat = model_latency(a, b, sgn);
        run_div(a, b, sgn, lat, bcnt, res);
        checks++;
        if (lat !== elat) begin
            failures++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, elat);
        end
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL %s result: got %h required %h", name, res, exp);
        end
        checks++;
        if (bcnt !== elat) begin
            failures++;
            $display("FAIL %s busy cycles: got %0d required %0d", name, bcnt, elat);
        end
        drop_start();
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s release: ready=%b result=%h busy=%b required 0/0/0",
                     name, bus.ready_o, bus.result_o, bus.busy_o);
        end
    endtask

    task automatic test_directed();
        test_div("udiv_100_7", 32'd100, 32'd7, 1'b0);
        test_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        test_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        test_div("div_zero", 32'd1234, 32'd0, 1'b1);
        test_div("udiv_max", 32'hFFFF_FFFF, 32'd1, 1'b0);
        test_div("early_5_9", 32'd5, 32'd9, 1'b0);
        test_div("early_sneg", 32'hFFFF_FFFB, 32'd9, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        sgn;
        for (int i = 0; i < 24; i++) begin
            a   = $urandom;
            b   = $urandom;
            sgn = 1'($urandom);
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(1, 20));
                1: b = 32'd0;
                2: a = 32'($urandom_range(0, 50));
                3: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            test_div("random", a, b, sgn);
        end
    endtask

    task automatic test_hold();
        int lat, bcnt;
        logic [63:0] res, exp;
        exp = model_result(32'd1000, 32'd33, 1'b0);
        run_div(32'd1000, 32'd33, 1'b0, lat, bcnt, res);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== exp || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL hold: ready=%b result=%h busy=%b required 1/%h/0",
                     bus.ready_o, bus.result_o, bus.busy_o, exp);
        end
        drop_start();
        checks++;
        if (bus.ready_o !== 1'b0) begin
            failures++;
            $display("FAIL hold release: ready=%b required 0", bus.ready_o);
        end
    endtask

    task automatic test_annul();
        int seen;
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.signed_div_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            failures++;
            $display("FAIL annul: busy=%b ready=%b result=%h required 0/0/0",
                     bus.busy_o, bus.ready_o, bus.result_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.ready_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL annul no result: ready high %0d cycles required 0", seen);
        end
        test_div("after_annul", 32'd100, 32'd7, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.opdata1_i    = 32'd99999;
        bus.opdata2_i    = 32'd13;
        bus.signed_div_i = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL pre-reset busy: got %b required 1", bus.busy_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            failures++;
            $display("FAIL async reset: busy=%b ready=%b result=%h required 0/0/0",
                     bus.busy_o, bus.ready_o, bus.result_o);
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        test_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        test_reset();
        test_directed();
        test_hold();
        test_annul();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle 32-bit divider that serves the execute stage and consumes the operands the ID/EX pipeline register delivers (ex_reg1 as dividend, ex_reg2 as divisor).
- Radix-2 restoring division producing quotient and remainder, signed or unsigned.
- While it is busy, the execute stage raises its stall request to the pipeline controller, which freezes ID/EX and the earlier stages until ready_o is high.

Parameters:
- DATA_W, 32, operand width; quotient and remainder each DATA_W bits.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-high
- start_i  input  1  request a divide; held high by EX until ready_o is seen
- annul_i  input  1  abandon the current operation (flush or exception)
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- opdata1_i  input  DATA_W  dividend
- opdata2_i  input  DATA_W  divisor
- result_o  output  2*DATA_W  {remainder, quotient}; upper half goes to HI, lower half to LO
- ready_o  output  1  result_o valid
- busy_o  output  1  high in states BYZERO and ON; EX ORs it into its stall request

Behaviour:
- Reset: asynchronous, active-high. On assertion:
  - state = FREE, result_o = 0, ready_o = 0, busy_o = 0, counter = 0.
  - Reset takes effect immediately, including mid-divide.
- States: FREE, BYZERO, ON, END. State is registered; busy_o is decoded from state.
- FREE:
  - start_i=1, annul_i=0, divisor==0: go to BYZERO.
  - start_i=1, annul_i=0, divisor!=0: go to ON. Latch operands as magnitudes: if signed_div_i and the operand's MSB is 1, store its two's-complement. Latch the sign flags. Clear the partial remainder; counter = 0.
  - Otherwise: stay in FREE; ready_o = 0, result_o = 0.
- BYZERO: go to END with result_o = 0 (quotient 0, remainder 0).
- ON:
  - Each cycle performs one iteration: shift {rem, dividend} left 1; trial = rem - divisor.
    - If trial is non-negative, rem = trial and the quotient bit = 1.
    - Otherwise the quotient bit = 0.
  - counter increments once per iteration; after DATA_W iterations, go to END.
- END entry (sign fix-up):
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend was negative.
  - Load result_o with the fixed-up values and set ready_o = 1.
- END: hold result_o and ready_o = 1 while start_i = 1. When start_i = 0, go to FREE, with ready_o = 0 and result_o = 0.
- Latency, with start_i sampled at edge N:
  - Normal path: DATA_W iterations on edges N+1..N+32; ready_o high after edge N+33.
  - Divide-by-zero: ready_o high after edge N+1.
- annul_i:
  - In BYZERO, ON or END: next edge goes to FREE with ready_o = 0 and result_o = 0. No result is produced.
  - annul_i has priority over all other transitions.
- Operand changes while busy are ignored; only the latched copies are used.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No trap is raised.
- start_i held high after ready_o does not restart the divide; a restart requires start_i to deassert for at least 1 cycle.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in FREE, with a valid start and a non-zero divisor, if the latched |dividend| < |divisor|, go directly to END. The result is quotient 0 and remainder = dividend (sign preserved); ready_o is high after edge N+1. For other operands, latency is unchanged.
- Not defined: every non-zero divisor takes the full DATA_W iterations.

Test Plan:
- Unsigned: opdata1_i = 100, opdata2_i = 7, signed_div_i = 0, start_i held → ready_o rises after edge N+33; result_o = {32'd2, 32'd14}; busy_o high for exactly 33 cycles.
- Signed: -7 (0xFFFFFFF9) / 2, signed_div_i = 1 → result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also 7 / -2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero: opdata2_i = 0 → ready_o after edge N+1, result_o = 0. Then drop start_i → FREE, ready_o = 0 on the next edge.
- Annul: pulse annul_i 10 cycles after start → FREE on the next edge, ready_o never rises. A new start then completes correctly (100/7 → 14 r 2).
- Reset: assert rst asynchronously mid-ON → result_o = 0, ready_o = 0, busy_o = 0 immediately without a clock edge. After reset, 0x80000000 / 0xFFFFFFFF signed → {0, 0x80000000}.
- DIV_EARLY_EXIT_EN defined: 5 / 9 unsigned → ready_o after edge N+1, result_o = {32'd5, 32'd0}. With the macro not defined, the same operands take 33 cycles.
